matrix_stream_ctrl: RTL and testbench
=====================================

// Module: matrix_stream_ctrl
// PURPOSE
// - Byte-stream front/back end for matrix_mult (3x3, 8-bit operands, 18-bit results) on an 8-bit pin budget.
// - Collects 18 operand bytes, holds them stable on A0..A8/B0..B8, and drives mm_enable until mm_done.
// - Snapshots C0..C8, then streams the results out as 27 bytes.
// - Sits directly upstream (operands) and downstream (results) of matrix_mult.
// PARAMETERS
// - DONE_TIMEOUT  default 15  max cycles in COMPUTE without mm_done before abort (>=4)
// PORTS
// - clk       in   1   single clock, rising edge
// - reset     in   1   asynchronous, active-low reset
// - in_data   in   8   operand byte
// - in_valid  in   1   in_data valid
// - in_ready  out  1   ctrl accepts in_data this cycle
// - A0..A8    out  8 each  operand matrix A, row-major, to matrix_mult
// - B0..B8    out  8 each  operand matrix B, row-major, to matrix_mult
// - mm_enable out  1   enable to matrix_mult
// - mm_done   in   1   done from matrix_mult
// - C0..C8    in   18 each  results from matrix_mult, valid while mm_done=1
// - out_data  out  8   result byte
// - out_valid out  1   out_data valid
// - out_ready in   1   sink accepts out_data this cycle
// - err       out  1   sticky timeout flag
// BEHAVIOUR
// - Reset (async, reset=0) clears all outputs and registers to 0: A*, B*, result shadow, counters, mm_enable, out_valid, err.
//   - After reset the state is LOAD; in_ready is 1 from the first cycle after release.
// - Transfers: input on in_valid&in_ready; output on out_valid&out_ready.
// - FSM states: LOAD -> COMPUTE -> SEND -> LOAD.
// - LOAD
//   - in_ready=1, mm_enable=0, out_valid=0.
//   - byte_cnt 0..17 maps to A0..A8 then B0..B8; each accepted byte is registered into its slot.
//   - Gaps in in_valid are allowed: no timeout, no loss.
//   - When byte 17 is accepted, go to COMPUTE next cycle with mm_enable=1 (registered) and byte_cnt=0.
// - COMPUTE
//   - in_ready=0; mm_enable held 1; A*/B* frozen; wait counter increments each cycle.
//   - When mm_done=1: latch C0..C8 into the shadow regs that same edge, drop mm_enable, go to SEND.
//   - Nominal mm_done arrives on the 3rd edge after mm_enable rises.
//   - If the wait counter reaches DONE_TIMEOUT without mm_done: set err=1, drop mm_enable, go to LOAD with byte_cnt=0.
//   - err stays 1 until reset.
// - SEND
//   - out_valid=1; 27 bytes, index r=0..8, b=0..2.
//   - Byte b=0 is Cr[7:0], b=1 is Cr[15:8], b=2 is {6'b0,Cr[17:16]}.
//   - out_data is stable while out_valid&!out_ready; it advances only on a transfer.
//   - After byte 26 transfers: out_valid=0 next cycle, go to LOAD, in_ready=1.
// - Streaming results come from the shadow regs only, so matrix_mult may clear C afterwards with no effect.
// - mm_enable is 0 for at least one cycle between jobs, so matrix_mult restarts with k=0.
// - A*/B* keep the last job's values until overwritten byte by byte in the next LOAD.
// - Reset mid-operation (any state) aborts immediately to the reset values; partial input and output bytes are discarded.
// - Widths: no arithmetic other than counters. byte_cnt is 5 bits (0..26) and wait counter is 4 bits, both saturating-safe.
// TESTING
// - Identity job: A=I (A0=A4=A8=1, else 0), B=1..9 -> mm_enable high exactly 3 cycles.
//   - out bytes: 01 00 00 02 00 00 ... 09 00 00.
// - Max operands: all 36... all 18 bytes = 0xFF -> each Cr=195075=0x2FA03.
//   - out bytes: (03 FA 02) repeated x9; err=0.
// - Backpressure: in_valid random 50% and out_ready toggling every cycle.
//   - Same bytes as the identity job; out_data never changes while stalled.
// - Back-to-back jobs: a second job follows immediately after byte 26.
//   - mm_enable has a >=1-cycle low gap; second result matches a golden 3x3 model.
// - Reset mid-SEND: reset=0 after 10 output bytes.
//   - out_valid=0 and in_ready=0 during reset; next job yields a full 27-byte correct result.
// - Timeout: mm_done tied 0 -> err=1 exactly DONE_TIMEOUT cycles after mm_enable rises.
//   - mm_enable=0 and in_ready=1 the following cycle.

Source files
------------

// File: rtl/matrix_stream_ctrl_if.sv
// Byte stream bundle used on both sides of matrix_stream_ctrl.
//   data  : 8-bit payload
//   valid : driven by the master, data is meaningful
//   ready : driven by the slave, it accepts data this cycle
// Handshake: a byte moves on every rising edge where valid && ready are both
// 1. A master holds data and valid steady until that edge. A slave may
// raise or drop ready at any cycle. Neither side waits on the other before
// driving its own signal.
interface matrix_stream_ctrl_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/matrix_stream_ctrl.sv
// Byte-stream front/back end for a 3x3 matrix_mult (8-bit operands, 18-bit
// results) on an 8-bit pin budget.
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-low reset
//   in_s  (slave)    18 operand bytes: A0..A8 then B0..B8, row-major
//   A0..A8, B0..B8   operands held stable for matrix_mult
//   mm_enable        enable to matrix_mult, high for the whole COMPUTE phase
//   mm_done          completion from matrix_mult; C0..C8 are valid with it
//   C0..C8           18-bit results from matrix_mult
//   out_s (master)   27 result bytes: per Cr, [7:0], [15:8], {6'b0,[17:16]}
//   err              sticky flag, set when mm_done never arrives in time
//   dbg_state        current FSM state (0 LOAD, 1 COMPUTE, 2 SEND)
module matrix_stream_ctrl #(
  parameter int DONE_TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  matrix_stream_ctrl_if.slave         in_s,
  output logic [7:0]                  A0, A1, A2, A3, A4, A5, A6, A7, A8,
  output logic [7:0]                  B0, B1, B2, B3, B4, B5, B6, B7, B8,
  output logic                        mm_enable,
  input  logic                        mm_done,
  input  logic [17:0]                 C0, C1, C2, C3, C4, C5, C6, C7, C8,
  matrix_stream_ctrl_if.master        out_s,
  output logic                        err,
  output logic [1:0]                  dbg_state
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_SEND    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  byte_cnt_q, byte_cnt_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        live_q;
  logic        mm_enable_q, out_valid_q, err_q;
  logic [7:0]  a_q [9];
  logic [7:0]  b_q [9];
  logic [17:0] c_q [9];
  logic [17:0] c_in [9];
  logic        in_fire, out_fire, capture, timeout;
  logic [7:0]  out_byte;

  assign c_in = '{C0, C1, C2, C3, C4, C5, C6, C7, C8};

  // live_q keeps in_ready low while reset is held and until the first edge
  // after release, even though the reset state is already LOAD.
  assign in_s.ready = live_q && (state_q == ST_LOAD);
  assign in_fire    = in_s.valid && in_s.ready;
  assign out_fire   = out_valid_q && out_s.ready;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    wait_cnt_d = wait_cnt_q;
    capture    = 1'b0;
    timeout    = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        if (in_fire) begin
          if (byte_cnt_q == 5'd17) begin
            byte_cnt_d = '0;
            wait_cnt_d = '0;
            state_d    = ST_COMPUTE;
          end else begin
            byte_cnt_d = byte_cnt_q + 5'd1;
          end
        end
      end
      ST_COMPUTE: begin
        // A done arriving on the timeout cycle still counts as success.
        if (mm_done) begin
          capture    = 1'b1;
          byte_cnt_d = '0;
          state_d    = ST_SEND;
        end else if (wait_cnt_q == 4'(DONE_TIMEOUT - 1)) begin
          timeout    = 1'b1;
          byte_cnt_d = '0;
          state_d    = ST_LOAD;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      ST_SEND: begin
        if (out_fire) begin
          if (byte_cnt_q == 5'd26) begin
            byte_cnt_d = '0;
            state_d    = ST_LOAD;
          end else begin
            byte_cnt_d = byte_cnt_q + 5'd1;
          end
        end
      end
      default: begin
        byte_cnt_d = '0;
        state_d    = ST_LOAD;
      end
    endcase
  end

  // Result byte select: index 3r+b picks lane b of Cr from the shadow copy.
  always_comb begin
    out_byte = '0;
    for (int r = 0; r < 9; r++) begin
      if (byte_cnt_q == 5'(3 * r))     out_byte = c_q[r][7:0];
      if (byte_cnt_q == 5'(3 * r + 1)) out_byte = c_q[r][15:8];
      if (byte_cnt_q == 5'(3 * r + 2)) out_byte = {6'b0, c_q[r][17:16]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_LOAD;
      byte_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      live_q      <= 1'b0;
      mm_enable_q <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      live_q      <= 1'b1;
      // Registered from next-state so both go high/low on the state edge.
      mm_enable_q <= (state_d == ST_COMPUTE);
      out_valid_q <= (state_d == ST_SEND);
      if (timeout) err_q <= 1'b1;
      if (in_fire) begin
        for (int i = 0; i < 9; i++) begin
          if (byte_cnt_q == 5'(i))     a_q[i] <= in_s.data;
          if (byte_cnt_q == 5'(i + 9)) b_q[i] <= in_s.data;
        end
      end
      if (capture) begin
        for (int i = 0; i < 9; i++) c_q[i] <= c_in[i];
      end
    end
  end

  assign {A0, A1, A2, A3, A4, A5, A6, A7, A8} =
    {a_q[0], a_q[1], a_q[2], a_q[3], a_q[4], a_q[5], a_q[6], a_q[7], a_q[8]};
  assign {B0, B1, B2, B3, B4, B5, B6, B7, B8} =
    {b_q[0], b_q[1], b_q[2], b_q[3], b_q[4], b_q[5], b_q[6], b_q[7], b_q[8]};

  assign mm_enable   = mm_enable_q;
  assign out_s.data  = out_byte;
  assign out_s.valid = out_valid_q;
  assign err         = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_matrix_stream_ctrl.sv
module tb_matrix_stream_ctrl;
  localparam int T_OUT = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  matrix_stream_ctrl_if in_if ();
  matrix_stream_ctrl_if out_if ();

  logic [7:0]  A0, A1, A2, A3, A4, A5, A6, A7, A8;
  logic [7:0]  B0, B1, B2, B3, B4, B5, B6, B7, B8;
  logic        mm_enable, mm_done, err;
  logic [1:0]  dbg_state;
  logic [17:0] c_mod [9];
  logic [7:0]  a_w [9];
  logic [7:0]  b_w [9];

  matrix_stream_ctrl #(.DONE_TIMEOUT(T_OUT)) dut (
    .clk(clk), .reset(reset), .in_s(in_if),
    .A0(A0), .A1(A1), .A2(A2), .A3(A3), .A4(A4), .A5(A5), .A6(A6), .A7(A7), .A8(A8),
    .B0(B0), .B1(B1), .B2(B2), .B3(B3), .B4(B4), .B5(B5), .B6(B6), .B7(B7), .B8(B8),
    .mm_enable(mm_enable), .mm_done(mm_done),
    .C0(c_mod[0]), .C1(c_mod[1]), .C2(c_mod[2]), .C3(c_mod[3]), .C4(c_mod[4]),
    .C5(c_mod[5]), .C6(c_mod[6]), .C7(c_mod[7]), .C8(c_mod[8]),
    .out_s(out_if), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- matrix_mult model ----------------
  // mm_done pulses on the 3rd edge after mm_enable rises; C is only driven
  // while mm_done is high, zero otherwise.
  int   mm_k = 0;
  logic done_en = 1'b1;
  always @(posedge clk) begin
    if (!mm_enable) mm_k <= 0;
    else            mm_k <= mm_k + 1;
  end
  assign mm_done = done_en && mm_enable && (mm_k == 2);
  assign a_w = '{A0, A1, A2, A3, A4, A5, A6, A7, A8};
  assign b_w = '{B0, B1, B2, B3, B4, B5, B6, B7, B8};
  always_comb begin
    for (int i = 0; i < 9; i++) c_mod[i] = '0;
    if (mm_done) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          c_mod[r*3+c] = 18'(a_w[r*3])   * 18'(b_w[c])
                       + 18'(a_w[r*3+1]) * 18'(b_w[3+c])
                       + 18'(a_w[r*3+2]) * 18'(b_w[6+c]);
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int rx_cnt = 0;
  always @(negedge clk) begin
    if (reset && out_if.valid) begin
      if (exp_q.size() == 0) begin
        check("out_unexpected", 32'(out_if.data), 32'hffff_ffff);
      end else begin
        // Checked every valid cycle, so a stalled byte must also hold steady.
        check("out_byte", 32'(out_if.data), 32'(exp_q[0]));
        if (out_if.ready) begin
          void'(exp_q.pop_front());
          rx_cnt++;
        end
      end
    end
  end

  int en_run = 0, last_en_len = 0, low_run = 0, last_gap = 0;
  always @(negedge clk) begin
    if (mm_enable) begin
      if (low_run > 0) begin last_gap = low_run; low_run = 0; end
      en_run++;
    end else begin
      if (en_run > 0) begin last_en_len = en_run; en_run = 0; end
      low_run++;
    end
  end

  // out_ready: always 1, or toggling every cycle
  bit ready_toggle = 1'b0;
  initial begin
    out_if.ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_toggle) out_if.ready = ~out_if.ready;
      else              out_if.ready = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_job(input logic [7:0] ops [18], input bit gaps);
    int t;
    int g;
    for (int i = 0; i < 18; i++) begin
      if (gaps) begin
        g = 0;
        while ($urandom_range(1, 0) == 1 && g < 4) begin
          in_if.valid = 1'b0;
          step();
          g++;
        end
      end
      in_if.data  = ops[i];
      in_if.valid = 1'b1;
      t = 0;
      while (!in_if.ready && t < 200) begin step(); t++; end
      if (t >= 200) check("in_ready_wait", 0, 1);
      step();
    end
    in_if.valid = 1'b0;
    in_if.data  = '0;
  endtask

  task automatic push_result(input logic [17:0] c [9]);
    for (int r = 0; r < 9; r++) begin
      exp_q.push_back(c[r][7:0]);
      exp_q.push_back(c[r][15:8]);
      exp_q.push_back({6'b0, c[r][17:16]});
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin step(); t++; end
    check("drain_done", 32'(exp_q.size()), 0);
  endtask

  function automatic void matmul(input logic [7:0] ops [18], output logic [17:0] c [9]);
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++) begin
        c[r*3+k] = '0;
        for (int j = 0; j < 3; j++)
          c[r*3+k] = c[r*3+k] + 18'(ops[r*3+j]) * 18'(ops[9+j*3+k]);
      end
  endfunction

  // ---------------- test sequence ----------------
  logic [7:0]  ops [18];
  logic [17:0] cexp [9];
  int          base;

  initial begin
    in_if.valid = 1'b0;
    in_if.data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_if.ready), 0);
    check("rst_out_valid", 32'(out_if.valid), 0);
    check("rst_mm_enable", 32'(mm_enable), 0);
    check("rst_err", 32'(err), 0);
    check("rst_A0", 32'(A0), 0);
    check("rst_state", 32'(dbg_state), 0);
    reset = 1'b1;
    step();
    check("post_rst_in_ready", 32'(in_if.ready), 1);

    // Identity job: A=I, B=1..9 -> C = 1..9
    for (int i = 0; i < 18; i++) ops[i] = '0;
    ops[0] = 8'd1; ops[4] = 8'd1; ops[8] = 8'd1;
    for (int i = 0; i < 9; i++) ops[9+i] = 8'(i + 1);
    for (int i = 0; i < 9; i++) cexp[i] = 18'(i + 1);
    push_result(cexp);
    send_job(ops, 1'b0);
    check("id_enable_rise", 32'(mm_enable), 1);
    check("id_state_compute", 32'(dbg_state), 1);
    check("id_in_ready_low", 32'(in_if.ready), 0);
    step(); step();
    check("id_enable_e2", 32'(mm_enable), 1);
    step();
    check("id_enable_fall", 32'(mm_enable), 0);
    check("id_out_valid", 32'(out_if.valid), 1);
    wait_drain();
    check("id_en_len", 32'(last_en_len), 3);
    check("id_out_valid_end", 32'(out_if.valid), 0);
    check("id_in_ready_end", 32'(in_if.ready), 1);
    check("id_hold_A4", 32'(A4), 1);
    check("id_hold_B8", 32'(B8), 9);

    // Max operands: every Cr = 3*255*255 = 0x2FA03 -> 03 FA 02
    for (int i = 0; i < 18; i++) ops[i] = 8'hff;
    for (int i = 0; i < 9; i++) cexp[i] = 18'h2fa03;
    push_result(cexp);
    send_job(ops, 1'b0);
    wait_drain();
    check("max_err", 32'(err), 0);

    // Backpressure: random input gaps, out_ready toggling; identity result
    for (int i = 0; i < 18; i++) ops[i] = '0;
    ops[0] = 8'd1; ops[4] = 8'd1; ops[8] = 8'd1;
    for (int i = 0; i < 9; i++) ops[9+i] = 8'(i + 1);
    for (int i = 0; i < 9; i++) cexp[i] = 18'(i + 1);
    push_result(cexp);
    ready_toggle = 1'b1;
    send_job(ops, 1'b1);
    wait_drain();
    ready_toggle = 1'b0;

    // Back-to-back: second job starts in the first LOAD cycle
    for (int i = 0; i < 18; i++) ops[i] = 8'(i + 1);
    for (int i = 0; i < 9; i++) ops[9+i] = 8'(200 - 17 * i);
    matmul(ops, cexp);
    push_result(cexp);
    send_job(ops, 1'b0);
    wait_drain();
    check("b2b_en_gap", 32'(last_gap >= 1), 1);
    check("b2b_en_len", 32'(last_en_len), 3);

    // Reset mid-SEND after 10 output bytes
    for (int i = 0; i < 18; i++) ops[i] = 8'(37 * i + 5);
    matmul(ops, cexp);
    push_result(cexp);
    base = rx_cnt;
    send_job(ops, 1'b0);
    begin
      int t = 0;
      while ((rx_cnt - base) < 10 && t < 200) begin step(); t++; end
      check("mid_send_10_bytes", 32'(rx_cnt - base), 10);
    end
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", 32'(out_if.valid), 0);
    check("mid_rst_in_ready", 32'(in_if.ready), 0);
    check("mid_rst_A0", 32'(A0), 0);
    check("mid_rst_state", 32'(dbg_state), 0);
    step(); step();
    reset = 1'b1;
    step();
    check("mid_post_in_ready", 32'(in_if.ready), 1);
    for (int i = 0; i < 18; i++) ops[i] = 8'(255 - 13 * i);
    matmul(ops, cexp);
    push_result(cexp);
    send_job(ops, 1'b0);
    wait_drain();

    // Timeout: mm_done never asserted
    done_en = 1'b0;
    send_job(ops, 1'b0);
    check("to_enable_rise", 32'(mm_enable), 1);
    repeat (T_OUT - 1) step();
    check("to_err_early", 32'(err), 0);
    check("to_enable_held", 32'(mm_enable), 1);
    step();
    check("to_err_set", 32'(err), 1);
    check("to_enable_drop", 32'(mm_enable), 0);
    check("to_in_ready", 32'(in_if.ready), 1);
    check("to_out_valid", 32'(out_if.valid), 0);

    // Recovery job after timeout; err stays sticky
    done_en = 1'b1;
    for (int i = 0; i < 18; i++) ops[i] = 8'(i * 11);
    matmul(ops, cexp);
    push_result(cexp);
    send_job(ops, 1'b0);
    wait_drain();
    check("to_err_sticky", 32'(err), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "global timeout");
  end
endmodule
